// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed 7-segment driver for the BCD adder result.
// It shows the carry digit plus hundreds, tens and units, with leading-zero blanking and a dash for non-BCD nibbles.
module bcd_display_scan #(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] sum,
  input  logic        carry,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    DIG_UNITS    = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2,
    DIG_CARRY    = 2'd3
  } digit_e;

  digit_e        idx_q, idx_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [12:0]   disp_q, disp_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          frame_q, frame_d;
  logic          wrap;
  logic [3:0]    nibble;
  logic          blank;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= DIG_UNITS;
      presc_q <= '0;
      disp_q  <= '0;
      seg_q   <= '0;
      an_q    <= '0;
      frame_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      presc_q <= presc_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  // Outputs are built from the pre-edge index and display value, so a load shows up one edge later.
  always_comb begin
    disp_d  = disp_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    nibble  = 4'd0;
    blank   = 1'b0;

    if (load) begin
      disp_d = {carry, sum};
    end

    wrap = (presc_q == PRESC_LAST);
    if (wrap) begin
      presc_d = '0;
      idx_d   = digit_e'(2'(idx_q + 2'd1));
    end else begin
      presc_d = PW'(presc_q + 1'b1);
    end

    // A digit blanks only if it and every more-significant digit are zero; invalid nibbles are nonzero.
    case (idx_q)
      DIG_UNITS: begin
        nibble = disp_q[3:0];
        blank  = 1'b0;
      end
      DIG_TENS: begin
        nibble = disp_q[7:4];
        blank  = (disp_q[12:4] == 9'd0);
      end
      DIG_HUNDREDS: begin
        nibble = disp_q[11:8];
        blank  = (disp_q[12:8] == 5'd0);
      end
      default: begin
        nibble = {3'b000, disp_q[12]};
        blank  = ~disp_q[12];
      end
    endcase

    seg_d   = blank ? 7'b0000000 : decode(nibble);
    an_d    = 4'b0001 << idx_q;
    frame_d = (idx_q == DIG_UNITS) && (an_q == 4'b1000);
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Checks two scanners (SCAN_DIV=4 and SCAN_DIV=1) on shared inputs against an arithmetic model
// that derives the digit, enable and frame from the cycle count since reset release.
module tb_bcd_display_scan;

   logic        clk;
   logic        rst;
   logic        load;
   logic [11:0] sum;
   logic        carry;

   logic [6:0]  seg4, seg1;
   logic [3:0]  an4, an1;
   logic        frame4, frame1;

   int compared;
   int mismatched;

   // Model state: edges since reset release and the value currently shown.
   int          cyc;
   logic [12:0] shown;

   logic [6:0]  expSeg4, expSeg1;
   logic [3:0]  expAn4, expAn1;
   logic        expFrame4, expFrame1;

   bcd_display_scan #(.SCAN_DIV(4)) dut4 (
      .clk(clk), .rst(rst), .load(load), .sum(sum), .carry(carry),
      .seg(seg4), .an(an4), .frame(frame4)
   );

   bcd_display_scan #(.SCAN_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .load(load), .sum(sum), .carry(carry),
      .seg(seg1), .an(an1), .frame(frame1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] glyph(input int n);
      logic [6:0] tbl [10];
      tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
      if (n > 9) return 7'b1000000;
      return tbl[n];
   endfunction

   function automatic int digitAt(input int k, input int div);
      return ((k - 1) / div) % 4;
   endfunction

   function automatic logic [6:0] modelSeg(input logic [12:0] v, input int dig);
      int nib [4];
      bit allZero;
      nib[0] = int'(v[3:0]);
      nib[1] = int'(v[7:4]);
      nib[2] = int'(v[11:8]);
      nib[3] = int'(v[12]);
      allZero = 1'b1;
      for (int j = dig; j < 4; j++) if (nib[j] != 0) allZero = 1'b0;
      if (dig != 0 && allZero) return 7'b0000000;
      return glyph(nib[dig]);
   endfunction

   // Computes the expected outputs for an edge, then applies the load the edge sampled.
   task automatic stepModel(input logic r, input logic l, input logic [11:0] s, input logic c);
      if (r) begin
         cyc = 0;
         shown = '0;
         expSeg4 = '0; expSeg1 = '0;
         expAn4 = '0;  expAn1 = '0;
         expFrame4 = 1'b0; expFrame1 = 1'b0;
      end else begin
         cyc++;
         expAn4 = 4'(1 << digitAt(cyc, 4));
         expAn1 = 4'(1 << digitAt(cyc, 1));
         expSeg4 = modelSeg(shown, digitAt(cyc, 4));
         expSeg1 = modelSeg(shown, digitAt(cyc, 1));
         expFrame4 = (cyc > 1) && ((cyc - 1) % 16 == 0);
         expFrame1 = (cyc > 1) && ((cyc - 1) % 4 == 0);
         if (l) shown = {c, s};
      end
   endtask

   task automatic checkOutput();
      compared++;
      assert (seg4 === expSeg4) else begin
         mismatched++;
         $error("[TB] FAIL seg4 cyc=%0d got=%b want=%b", cyc, seg4, expSeg4);
      end
      compared++;
      assert (an4 === expAn4) else begin
         mismatched++;
         $error("[TB] FAIL an4 cyc=%0d got=%b want=%b", cyc, an4, expAn4);
      end
      compared++;
      assert (frame4 === expFrame4) else begin
         mismatched++;
         $error("[TB] FAIL frame4 cyc=%0d got=%b want=%b", cyc, frame4, expFrame4);
      end
      compared++;
      assert (seg1 === expSeg1) else begin
         mismatched++;
         $error("[TB] FAIL seg1 cyc=%0d got=%b want=%b", cyc, seg1, expSeg1);
      end
      compared++;
      assert (an1 === expAn1) else begin
         mismatched++;
         $error("[TB] FAIL an1 cyc=%0d got=%b want=%b", cyc, an1, expAn1);
      end
      compared++;
      assert (frame1 === expFrame1) else begin
         mismatched++;
         $error("[TB] FAIL frame1 cyc=%0d got=%b want=%b", cyc, frame1, expFrame1);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic l, input logic [11:0] s, input logic c);
      @(negedge clk);
      rst = r; load = l; sum = s; carry = c;
      @(posedge clk);
      #1;
      stepModel(r, l, s, c);
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
   endtask

   task automatic reportTimeout(input string tag);
      compared++;
      mismatched++;
      $error("[TB] FAIL %s got=timeout want=reached", tag);
   endtask

   initial begin
      bit found;
      compared = 0;
      mismatched = 0;
      cyc = 0;
      shown = '0;
      rst = 1'b1; load = 1'b0; sum = '0; carry = 1'b0;

      $display("[TB] reset and release");
      applyStimulus(1'b1, 1'b0, 12'h000, 1'b0);
      applyStimulus(1'b1, 1'b1, 12'h999, 1'b1);
      idle(17);

      $display("[TB] directed values");
      applyStimulus(1'b0, 1'b1, 12'h999, 1'b1);
      idle(16);
      applyStimulus(1'b0, 1'b1, 12'h100, 1'b0);
      idle(16);
      applyStimulus(1'b0, 1'b1, 12'h00A, 1'b0);
      idle(16);
      applyStimulus(1'b0, 1'b1, 12'h0B0, 1'b0);
      idle(16);

      $display("[TB] load mid-scan on hundreds digit");
      found = 1'b0;
      for (int i = 0; i < 32 && !found; i++) begin
         if (digitAt(cyc, 4) == 2 && (cyc - 1) % 4 == 1) found = 1'b1;
         else idle(1);
      end
      if (!found) reportTimeout("midscan_wait");
      applyStimulus(1'b0, 1'b1, 12'h225, 1'b0);
      idle(20);

      $display("[TB] reset mid-scan on tens digit");
      applyStimulus(1'b0, 1'b1, 12'h347, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 32 && !found; i++) begin
         if (digitAt(cyc, 4) == 1 && cyc > 0) found = 1'b1;
         else idle(1);
      end
      if (!found) reportTimeout("reset_wait");
      applyStimulus(1'b1, 1'b1, 12'h888, 1'b1);
      idle(20);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                       12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
      end
      idle(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
